// File: rtl/branch_resolve_unit.sv
// In-order resolution queue for gshare predictions: trains the table, redirects fetch on a miss.
// Optional statistics counters are built only when BRU_STATS_EN is defined.
module branch_resolve_unit #(
    parameter int HISTORY_SIZE = 4,
    parameter int DEPTH        = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       pred_valid_i,
    output logic                       pred_ready_o,
    input  logic                       pred_taken_i,
    input  logic [31:0]                pred_PC_i,
    input  logic [31:0]                pred_seq_PC_i,
    input  logic [HISTORY_SIZE-1:0]    pred_index_i,
    input  logic                       res_valid_i,
    input  logic                       res_taken_i,
    input  logic [31:0]                res_target_i,
    output logic                       upd_valid_o,
    output logic [HISTORY_SIZE-1:0]    upd_index_o,
    output logic                       upd_taken_o,
    output logic [31:0]                upd_target_o,
    output logic                       mispredict_o,
    output logic [31:0]                redirect_PC_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic [CNT_WIDTH-1:0]       branch_count_o,
    output logic [CNT_WIDTH-1:0]       mispredict_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;
    state_t state;

    logic                    q_taken [DEPTH];
    logic [31:0]             q_pc    [DEPTH];
    logic [31:0]             q_seq   [DEPTH];
    logic [HISTORY_SIZE-1:0] q_index [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;

    logic                    push;
    logic                    resolve;
    logic                    miss;
    logic                    head_taken;
    logic [31:0]             head_pc;
    logic [31:0]             head_seq;
    logic [HISTORY_SIZE-1:0] head_index;

    assign occupancy_o  = count;
    assign pred_ready_o = (state == RUN) && (count < FULL);

    assign head_taken = q_taken[rd_ptr];
    assign head_pc    = q_pc[rd_ptr];
    assign head_seq   = q_seq[rd_ptr];
    assign head_index = q_index[rd_ptr];

    // Resolves never bypass a same-cycle push: an empty queue makes the resolve an orphan.
    assign push    = pred_valid_i && pred_ready_o;
    assign resolve = res_valid_i && (state == RUN) && (count != '0);
    assign miss    = resolve &&
                     ((res_taken_i != head_taken) ||
                      (res_taken_i && head_taken && (res_target_i != head_pc)));

    always_ff @(posedge clk_i) begin
        if (push && !miss) begin
            q_taken[wr_ptr] <= pred_taken_i;
            q_pc[wr_ptr]    <= pred_PC_i;
            q_seq[wr_ptr]   <= pred_seq_PC_i;
            q_index[wr_ptr] <= pred_index_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= RUN;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            upd_valid_o   <= 1'b0;
            upd_index_o   <= '0;
            upd_taken_o   <= 1'b0;
            upd_target_o  <= '0;
            mispredict_o  <= 1'b0;
            redirect_PC_o <= '0;
        end else begin
            upd_valid_o  <= resolve;
            mispredict_o <= miss;
            if (resolve) begin
                upd_index_o  <= head_index;
                upd_taken_o  <= res_taken_i;
                upd_target_o <= res_target_i;
            end
            if (miss) begin
                redirect_PC_o <= res_taken_i ? res_target_i : head_seq;
            end

            case (state)
                RUN:     state <= miss ? FLUSH : RUN;
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase

            // Everything younger than the mispredicted branch is wrong-path.
            if (miss) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (resolve)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !resolve)
                    count <= count + OCC_W'(1);
                else if (!push && resolve)
                    count <= count - OCC_W'(1);
            end
        end
    end

`ifdef BRU_STATS_EN
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] miss_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            if (resolve && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            if (miss && (miss_cnt != '1))
                miss_cnt <= miss_cnt + CNT_WIDTH'(1);
        end
    end

    assign branch_count_o     = branch_cnt;
    assign mispredict_count_o = miss_cnt;
`else
    assign branch_count_o     = '0;
    assign mispredict_count_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a queue-level model predicts every update packet.
module tb_branch_resolve_unit;

    localparam int HS    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int PW    = 1 + 32 + HS + 1 + 32;
    localparam int CMAX  = (1 << CW) - 1;

    logic               clk_i = 1'b0;
    logic               reset_i = 1'b1;
    logic               pred_valid_i = 1'b0;
    logic               pred_ready_o;
    logic               pred_taken_i = 1'b0;
    logic [31:0]        pred_PC_i = '0;
    logic [31:0]        pred_seq_PC_i = '0;
    logic [HS-1:0]      pred_index_i = '0;
    logic               res_valid_i = 1'b0;
    logic               res_taken_i = 1'b0;
    logic [31:0]        res_target_i = '0;
    logic               upd_valid_o;
    logic [HS-1:0]      upd_index_o;
    logic               upd_taken_o;
    logic [31:0]        upd_target_o;
    logic               mispredict_o;
    logic [31:0]        redirect_PC_o;
    logic [$clog2(DEPTH):0] occupancy_o;
    logic [CW-1:0]      branch_count_o;
    logic [CW-1:0]      mispredict_count_o;

    branch_resolve_unit #(.HISTORY_SIZE(HS), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o),
        .pred_taken_i(pred_taken_i), .pred_PC_i(pred_PC_i),
        .pred_seq_PC_i(pred_seq_PC_i), .pred_index_i(pred_index_i),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
        .upd_valid_o(upd_valid_o), .upd_index_o(upd_index_o),
        .upd_taken_o(upd_taken_o), .upd_target_o(upd_target_o),
        .mispredict_o(mispredict_o), .redirect_PC_o(redirect_PC_o),
        .occupancy_o(occupancy_o), .branch_count_o(branch_count_o),
        .mispredict_count_o(mispredict_count_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Expected update packet: {mispredict, redirect_PC, index, taken, target}
    logic [PW-1:0] exp_q[$];

    typedef struct {
        logic          taken;
        logic [31:0]   pc;
        logic [31:0]   seq;
        logic [HS-1:0] idx;
    } pred_t;

    pred_t       mq[$];
    bit          m_flush;
    int          m_bc;
    int          m_mc;
    logic [31:0] m_redir;

    function automatic void check(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic int exp_cnt(int v);
`ifdef BRU_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic do_reset();
        pred_valid_i = 1'b0;
        res_valid_i  = 1'b0;
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        mq.delete();
        exp_q.delete();
        m_flush = 0;
        m_bc = 0;
        m_mc = 0;
        m_redir = '0;
        check("reset_ready", pred_ready_o, 1);
        check("reset_occ", occupancy_o, 0);
        check("reset_outs", {upd_valid_o, mispredict_o, redirect_PC_o, upd_target_o}, 0);
        check("reset_counts", {branch_count_o, mispredict_count_o}, 0);
    endtask

    // Driver: one cycle of stimulus plus the model's view of that cycle.
    task automatic cycle(input logic pv, input logic pt, input logic [31:0] ppc,
                         input logic [31:0] pseq, input logic [HS-1:0] pidx,
                         input logic rv, input logic rt, input logic [31:0] rtgt);
        bit    ready, push, resolve, miss;
        pred_t h, n;
        ready = !m_flush && (mq.size() < DEPTH);
        check("pred_ready", pred_ready_o, ready);
        pred_valid_i  = pv;
        pred_taken_i  = pt;
        pred_PC_i     = ppc;
        pred_seq_PC_i = pseq;
        pred_index_i  = pidx;
        res_valid_i   = rv;
        res_taken_i   = rt;
        res_target_i  = rtgt;

        push    = pv && ready;
        resolve = rv && !m_flush && (mq.size() > 0);
        miss    = 0;
        if (resolve) begin
            h = mq.pop_front();
            miss = (rt != h.taken) || (rt && h.taken && (rtgt != h.pc));
            if (m_bc < CMAX) m_bc++;
            if (miss) begin
                if (m_mc < CMAX) m_mc++;
                m_redir = rt ? rtgt : h.seq;
            end
            exp_q.push_back({miss, m_redir, h.idx, rt, rtgt});
        end
        if (miss) begin
            mq.delete();
        end else if (push) begin
            n.taken = pt; n.pc = ppc; n.seq = pseq; n.idx = pidx;
            mq.push_back(n);
        end
        m_flush = miss;

        @(posedge clk_i);
        #1;
        pred_valid_i = 1'b0;
        res_valid_i  = 1'b0;
        check("occupancy", occupancy_o, mq.size());
        check("branch_count", branch_count_o, exp_cnt(m_bc));
        check("mispredict_count", mispredict_count_o, exp_cnt(m_mc));
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic random_cycle();
        logic          pv, rv, rt;
        logic [31:0]   rtgt;
        pv = ($urandom_range(0, 2) != 0);
        rv = ($urandom_range(0, 1) != 0);
        if (mq.size() > 0) begin
            rt   = ($urandom_range(0, 3) != 0) ? mq[0].taken : ~mq[0].taken;
            rtgt = ($urandom_range(0, 3) != 0) ? mq[0].pc : {$urandom_range(0, 255), 2'b00};
        end else begin
            rt   = $urandom_range(0, 1);
            rtgt = {$urandom_range(0, 255), 2'b00};
        end
        cycle(pv, $urandom_range(0, 1), {$urandom_range(0, 255), 2'b00},
              {$urandom_range(0, 255), 2'b00}, $urandom_range(0, (1 << HS) - 1),
              rv, rt, rtgt);
    endtask

    // Monitor / scoreboard
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (upd_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_update actual=1 required=0 at %0t", $time);
                end else begin
                    logic [PW-1:0] e;
                    e = exp_q.pop_front();
                    check("upd_packet",
                          {mispredict_o, redirect_PC_o, upd_index_o, upd_taken_o, upd_target_o}, e);
                end
            end else begin
                check("mispredict_without_update", mispredict_o, 0);
            end
        end
    end

    initial begin
        do_reset();

        // Fill, then a dropped fifth push
        cycle(1, 1, 32'h100, 32'h104, 4'h1, 0, 0, 0);
        cycle(1, 1, 32'h200, 32'h204, 4'h2, 0, 0, 0);
        cycle(1, 1, 32'h300, 32'h304, 4'h3, 0, 0, 0);
        cycle(1, 1, 32'h400, 32'h404, 4'h4, 0, 0, 0);
        check("full_occ", occupancy_o, 4);
        cycle(1, 1, 32'h500, 32'h504, 4'h5, 0, 0, 0);
        // Correct resolve, then taken with wrong target
        cycle(0, 0, 0, 0, 0, 1, 1, 32'h100);
        check("after_correct_occ", occupancy_o, 3);
        cycle(0, 0, 0, 0, 0, 1, 1, 32'h250);
        check("redirect_target", redirect_PC_o, 32'h250);
        check("flush_ready", pred_ready_o, 0);
        cycle(1, 1, 32'h900, 32'h904, 4'h9, 1, 1, 32'h900);
        // Predicted taken, resolved not-taken
        cycle(1, 1, 32'h600, 32'h504, 4'hA, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h0);
        check("redirect_seq", redirect_PC_o, 32'h504);
        idle();
        // Orphan resolves
        cycle(0, 0, 0, 0, 0, 1, 1, 32'h40);
        cycle(1, 0, 32'h700, 32'h704, 4'h7, 1, 0, 32'h0);
        check("orphan_occ", occupancy_o, 1);
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h0);

        for (int i = 0; i < 400; i++) random_cycle();

        // Reset mid-operation with entries queued
        cycle(1, 1, 32'h800, 32'h804, 4'h8, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 200; i++) random_cycle();

        // Saturation of the branch counter
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 32'h1000 + 32'(i * 4), 32'h2000, 4'(i), 0, 0, 0);
            cycle(0, 0, 0, 0, 0, 1, 1, 32'h1000 + 32'(i * 4));
        end
        check("branch_count_sat", branch_count_o, exp_cnt(CMAX));

        repeat (3) idle();
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
